// File: rtl/alu_pkg.sv
// Shared constants for the ADD/AND/CMP ALU slice.
//   Opcode encodings : OP_ADD, OP_AND, OP_CMP (4 bits)
//   Flag bit indices : FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0 within {N,Z,C,V}
package alu_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned FLAGS_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_CMP = 4'b1011;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage : alu_pkg

// File: rtl/alu_add_and_cmp_if.sv
// Request/response bundle for alu_add_and_cmp.
//   Request  : in_valid, Reg1, Reg2, OpCode, S, Flag
//   Response : Result, New_Flag, out_valid, op_err
//   master = requester (drives request), slave = ALU (drives response)
interface alu_add_and_cmp_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic                in_valid;
  logic [WIDTH-1:0]    Reg1;
  logic [WIDTH-1:0]    Reg2;
  logic [OPCODE_W-1:0] OpCode;
  logic                S;
  logic [FLAGS_W-1:0]  Flag;

  logic [WIDTH-1:0]    Result;
  logic [FLAGS_W-1:0]  New_Flag;
  logic                out_valid;
  logic                op_err;

  modport master (
    output in_valid, Reg1, Reg2, OpCode, S, Flag,
    input  Result, New_Flag, out_valid, op_err
  );

  modport slave (
    input  in_valid, Reg1, Reg2, OpCode, S, Flag,
    output Result, New_Flag, out_valid, op_err
  );

endinterface : alu_add_and_cmp_if

// File: rtl/alu_addsub.sv
// Shared WIDTH-bit adder/subtractor used by ADD and CMP.
//   a_i, b_i  : operands
//   sub_i     : 1 = a_i - b_i (b inverted, carry-in set), 0 = a_i + b_i
//   sum_c     : WIDTH-bit result
//   carry_c   : carry-out (for subtract: 1 means no borrow, a_i >= b_i unsigned)
//   ovf_c     : two's-complement overflow
module alu_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_c,
  output logic             carry_c,
  output logic             ovf_c
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [WIDTH-1:0] b_eff;
  logic [SUM_W-1:0] full;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign full  = {1'b0, a_i} + {1'b0, b_eff} + SUM_W'(sub_i);

  assign sum_c   = full[WIDTH-1:0];
  assign carry_c = full[WIDTH];
  // Overflow: effective operands share a sign, result sign differs.
  assign ovf_c   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_c[WIDTH-1] != a_i[WIDTH-1]);

endmodule : alu_addsub

// File: rtl/alu_add_and_cmp.sv
// Single-cycle ALU: ADD, AND and (optionally) CMP with {N,Z,C,V} flags.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alu_add_and_cmp_if.slave (request in, registered response out)
// Configuration macro: ALU_CMP_OP_EN enables CMP; when undefined, OpCode
// 4'b1011 is reported as unsupported and the subtract path is tied off.
module alu_add_and_cmp
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  alu_add_and_cmp_if.slave   bus
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0]   result_q,    result_d;
  logic [FLAGS_W-1:0] flag_q,      flag_d;
  logic               out_valid_q, out_valid_d;
  logic               op_err_q,    op_err_d;

  logic               sub_c;
  logic [WIDTH-1:0]   sum_c;
  logic               carry_c;
  logic               ovf_c;
  logic [WIDTH-1:0]   and_c;

  // Shared adder: ADD uses it directly, CMP drives it in subtract mode.
  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a_i     (bus.Reg1),
    .b_i     (bus.Reg2),
    .sub_i   (sub_c),
    .sum_c   (sum_c),
    .carry_c (carry_c),
    .ovf_c   (ovf_c)
  );

  assign and_c = bus.Reg1 & bus.Reg2;

  // Next-state decode; idle cycles hold Result/New_Flag and clear pulses.
  always_comb begin
    result_d    = result_q;
    flag_d      = flag_q;
    out_valid_d = 1'b0;
    op_err_d    = 1'b0;
    sub_c       = 1'b0;

    if (bus.in_valid) begin
      out_valid_d = 1'b1;
      flag_d      = bus.Flag;
      unique case (bus.OpCode)
        OP_ADD: begin
          result_d = sum_c;
          if (bus.S) begin
            flag_d[FLAG_N] = sum_c[MSB];
            flag_d[FLAG_Z] = (sum_c == '0);
            flag_d[FLAG_C] = carry_c;
            flag_d[FLAG_V] = ovf_c;
          end
        end
        OP_AND: begin
          result_d = and_c;
          // C and V pass through from Flag (already the default).
          if (bus.S) begin
            flag_d[FLAG_N] = and_c[MSB];
            flag_d[FLAG_Z] = (and_c == '0);
          end
        end
`ifdef ALU_CMP_OP_EN
        OP_CMP: begin
          // Flags always update; Result is left untouched.
          sub_c          = 1'b1;
          flag_d[FLAG_N] = sum_c[MSB];
          flag_d[FLAG_Z] = (sum_c == '0);
          flag_d[FLAG_C] = carry_c;
          flag_d[FLAG_V] = ovf_c;
        end
`else
        OP_CMP: begin
          op_err_d = 1'b1;
        end
`endif
        default: begin
          op_err_d = 1'b1;
        end
      endcase
    end
  end

  // Response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      flag_q      <= '0;
      out_valid_q <= 1'b0;
      op_err_q    <= 1'b0;
    end else begin
      result_q    <= result_d;
      flag_q      <= flag_d;
      out_valid_q <= out_valid_d;
      op_err_q    <= op_err_d;
    end
  end

  assign bus.Result    = result_q;
  assign bus.New_Flag  = flag_q;
  assign bus.out_valid = out_valid_q;
  assign bus.op_err    = op_err_q;

endmodule : alu_add_and_cmp

// File: tb/tb_alu_add_and_cmp.sv
// Directed self-checking bench for alu_add_and_cmp (WIDTH=32).
// Expectations for OpCode 4'b1011 follow ALU_CMP_OP_EN as compiled.
module tb_alu_add_and_cmp;

  localparam int unsigned WIDTH = 32;

  logic clk;
  logic rst;

  int unsigned n_checks;
  int unsigned n_fail;

  alu_add_and_cmp_if #(.WIDTH(WIDTH)) bus ();

  alu_add_and_cmp #(
    .WIDTH (WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] res, input logic [3:0] flg,
                           input logic ov, input logic err);
    check({tag, ".Result"},    bus.Result,             res);
    check({tag, ".New_Flag"},  {28'd0, bus.New_Flag},  {28'd0, flg});
    check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
    check({tag, ".op_err"},    {31'd0, bus.op_err},    {31'd0, err});
  endtask

  // Present one request at the falling edge, sample #1 after the next rising edge.
  task automatic issue(input logic [3:0] op, input logic s, input logic [3:0] flg,
                       input logic [31:0] r1, input logic [31:0] r2);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.OpCode   = op;
    bus.S        = s;
    bus.Flag     = flg;
    bus.Reg1     = r1;
    bus.Reg2     = r2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.Flag     = 4'b1111;
    @(posedge clk);
    #1;
  endtask

  logic cmp_en;
  logic [3:0] exp_f;

  initial begin
    n_checks = 0;
    n_fail   = 0;
`ifdef ALU_CMP_OP_EN
    cmp_en = 1'b1;
`else
    cmp_en = 1'b0;
`endif
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.OpCode   = 4'b0000;
    bus.S        = 1'b0;
    bus.Flag     = 4'b0000;
    bus.Reg1     = '0;
    bus.Reg2     = '0;

    #1;
    check_out("reset", 32'h0, 4'b0000, 1'b0, 1'b0);

    // Request held during reset is discarded.
    issue(4'b0000, 1'b1, 4'b0000, 32'd5, 32'd7);
    check_out("req_in_reset", 32'h0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_out("first_after_reset", 32'd12, 4'b0000, 1'b1, 1'b0);

    idle();
    check_out("idle_hold", 32'd12, 4'b0000, 1'b0, 1'b0);

    issue(4'b0000, 1'b1, 4'b0000, 32'd5, 32'd7);
    check_out("add_5_7", 32'd12, 4'b0000, 1'b1, 1'b0);

    issue(4'b0000, 1'b1, 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
    check_out("add_ovf", 32'h8000_0000, 4'b1001, 1'b1, 1'b0);

    issue(4'b0000, 1'b0, 4'b0110, 32'h7FFF_FFFF, 32'h0000_0001);
    check_out("add_ovf_s0", 32'h8000_0000, 4'b0110, 1'b1, 1'b0);

    issue(4'b0000, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001);
    check_out("add_wrap", 32'h0, 4'b0110, 1'b1, 1'b0);

    issue(4'b0100, 1'b1, 4'b0011, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    check_out("and_zero", 32'h0, 4'b0111, 1'b1, 1'b0);

    issue(4'b0100, 1'b1, 4'b0000, 32'hFFFF_0000, 32'hF0F0_F0F0);
    check_out("and_neg", 32'hF0F0_0000, 4'b1000, 1'b1, 1'b0);

    issue(4'b0100, 1'b0, 4'b0101, 32'h0000_00FF, 32'h0000_0F0F);
    check_out("and_s0", 32'h0000_000F, 4'b0101, 1'b1, 1'b0);

    // Back-to-back requests, no idle between them.
    issue(4'b0000, 1'b1, 4'b0000, 32'd1, 32'd2);
    check_out("b2b_0", 32'd3, 4'b0000, 1'b1, 1'b0);
    issue(4'b0000, 1'b1, 4'b0000, 32'd5, 32'd7);
    check_out("b2b_1", 32'd12, 4'b0000, 1'b1, 1'b0);

    // CMP: Result stays 12 either way.
    exp_f = cmp_en ? 4'b1000 : 4'b0000;
    issue(4'b1011, 1'b0, 4'b0000, 32'd3, 32'd5);
    check_out("cmp_3_5", 32'd12, exp_f, 1'b1, ~cmp_en);

    exp_f = cmp_en ? 4'b0110 : 4'b0000;
    issue(4'b1011, 1'b0, 4'b0000, 32'd5, 32'd5);
    check_out("cmp_5_5", 32'd12, exp_f, 1'b1, ~cmp_en);

    exp_f = cmp_en ? 4'b0011 : 4'b1100;
    issue(4'b1011, 1'b0, 4'b1100, 32'h8000_0000, 32'h0000_0001);
    check_out("cmp_ovf", 32'd12, exp_f, 1'b1, ~cmp_en);

    issue(4'b0001, 1'b1, 4'b1010, 32'd9, 32'd9);
    check_out("bad_op", 32'd12, 4'b1010, 1'b1, 1'b1);

    idle();
    check_out("after_err", 32'd12, 4'b1010, 1'b0, 1'b0);

    // Asynchronous reset while a response pulse is live.
    issue(4'b0000, 1'b1, 4'b0000, 32'd5, 32'd7);
    check_out("pre_rst", 32'd12, 4'b0000, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check_out("async_rst", 32'h0, 4'b0000, 1'b0, 1'b0);

    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    issue(4'b0000, 1'b1, 4'b0000, 32'hFFFF_FFFE, 32'h0000_0003);
    check_out("post_rst_add", 32'h0000_0001, 4'b0010, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_add_and_cmp

// File: doc/alu_add_and_cmp.md
ALU_ADD_AND_CMP -- requirements
Module: alu_add_and_cmp

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width in bits (minimum 2).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset; the ports are listed below.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation request, sampled each rising edge.
REQ-006 Reg1  input  WIDTH  first operand, two's complement.
REQ-007 Reg2  input  WIDTH  second operand, two's complement.
REQ-008 OpCode  input  4  operation: 4'b0000 ADD, 4'b0100 AND, 4'b1011 CMP.
REQ-009 S  input  1  set-flags enable for ADD/AND.
REQ-010 Flag  input  4  current flags {N,Z,C,V}: bit3 N, bit2 Z, bit1 C, bit0 V.
REQ-011 Result  output  WIDTH  registered result.
REQ-012 New_Flag  output  4  registered flags {N,Z,C,V}.
REQ-013 out_valid  output  1  one-cycle pulse marking Result/New_Flag updated.
REQ-014 op_err  output  1  one-cycle pulse marking an unsupported OpCode.

Function
REQ-015 Latency SHALL be exactly 1 cycle: a request accepted at edge k drives out_valid=1 from edge k until edge k+1; there is no back-pressure, and a new request SHALL be accepted every cycle.
REQ-016 With in_valid=0, out_valid and op_err SHALL be 0 and Result/New_Flag SHALL hold.
REQ-017 ADD SHALL register Result = (Reg1+Reg2) mod 2^WIDTH.
REQ-018 ADD with S=1 SHALL set N=Result[MSB], Z=(Result==0), C=unsigned carry-out, V=signed overflow (operands of equal sign, result of different sign).
REQ-019 AND SHALL register Result = Reg1 & Reg2; with S=1, N and Z SHALL update, and C and V SHALL be copied from Flag.
REQ-020 For ADD and AND with S=0, New_Flag SHALL equal Flag.
REQ-021 CMP SHALL compute Reg1-Reg2 internally and SHALL leave Result unchanged.
REQ-022 CMP SHALL always update flags regardless of S: N=diff[MSB], Z=(Reg1==Reg2), C=1 iff Reg1>=Reg2 unsigned (no borrow), V=signed overflow of the subtraction.
REQ-023 For an unsupported OpCode with in_valid=1, out_valid=1 and op_err=1 SHALL pulse, Result SHALL hold, and New_Flag SHALL equal Flag.
REQ-024 Width boundary: 0x7FFFFFFF+1 SHALL produce 0x80000000 with V=1 and C=0; 0xFFFFFFFF+1 SHALL produce 0 with Z=1, C=1 and V=0.

Reset
REQ-025 While rst=1, Result=0, New_Flag=4'b0000, out_valid=0 and op_err=0, asynchronously.
REQ-026 A request presented on the edge where rst is asserted or held SHALL be discarded; the first request is accepted on the first rising edge with rst=0.

Configuration
REQ-027 With macro ALU_CMP_OP_EN defined, CMP SHALL behave per REQ-021/REQ-022.
REQ-028 Without ALU_CMP_OP_EN, OpCode 4'b1011 SHALL be treated as unsupported per REQ-023, and the subtract path SHALL be absent from the netlist.

Structure
REQ-029 Package alu_pkg SHALL hold the opcode constants (OP_ADD, OP_AND, OP_CMP) and the flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
REQ-030 A single sub-module, alu_addsub, SHALL provide a shared WIDTH-bit adder/subtractor (sub input inverts Reg2 and sets carry-in) with sum, carry and overflow outputs, used by ADD and CMP.

Verification
REQ-031 ADD, S=1, Reg1=5, Reg2=7, Flag=0 -> next cycle Result=12, New_Flag=0000, out_valid=1.
REQ-032 ADD, S=1, 0x7FFFFFFF+0x00000001 -> Result=0x80000000, New_Flag=1001; repeating with S=0 and Flag=0110 -> New_Flag=0110.
REQ-033 AND, S=1, Flag=0011, 0xF0F0F0F0 & 0x0F0F0F0F -> Result=0, New_Flag=0111.
REQ-034 Issue ADD 5+7, then CMP, S=0, Reg1=3, Reg2=5 -> Result stays 12, New_Flag=1000; CMP Reg1=5, Reg2=5 -> New_Flag=0110.
REQ-035 OpCode=4'b0001 with in_valid=1 -> op_err=1, Result holds, New_Flag=Flag; the same check with ALU_CMP_OP_EN undefined and OpCode=1011 gives the same response.
REQ-036 Assert rst mid-stream after Result=12 -> Result=0, New_Flag=0 and out_valid=0 immediately, without waiting for a clock edge.
